// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared owner encoding and default widths for the memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational two-way picker; a_first selects the winner when both request.
module mem_arb_pick (
  input  logic       a_req,
  input  logic       b_req,
  input  logic       a_first,
  output logic [1:0] gnt
);
  always_comb begin
    gnt[0] = a_req && (!b_req || a_first);
    gnt[1] = b_req && !gnt[0];
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and load/store, steering read data back to the owner.
// Define MEM_ARB_RR_EN for round-robin on contention; otherwise data always wins.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ready,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);
  logic [1:0] gnt;
  logic       favor_d;
  logic       if_req_g, d_req_g;
  owner_e     owner_q, owner_d;
  // Requests are masked during reset so ready and mem_* stay low.
  assign if_req_g = if_req && reset;
  assign d_req_g  = d_req && reset;
  mem_arb_pick u_pick (
    .a_req  (d_req_g),
    .b_req  (if_req_g),
    .a_first(favor_d),
    .gnt    (gnt)
  );
`ifdef MEM_ARB_RR_EN
  logic favor_d_q, favor_d_d;
  assign favor_d   = favor_d_q;
  assign favor_d_d = (if_req_g && d_req_g) ? !favor_d_q : favor_d_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) favor_d_q <= 1'b1;
    else        favor_d_q <= favor_d_d;
`else
  assign favor_d = 1'b1;
`endif
  always_comb begin
    d_ready   = gnt[0];
    if_ready  = gnt[1];
    mem_en    = |gnt;
    mem_we    = gnt[0] && d_we;
    mem_be    = (gnt[0] && d_we) ? d_be : '0;
    mem_addr  = gnt[0] ? d_addr : gnt[1] ? if_addr : '0;
    mem_wdata = gnt[0] ? d_wdata : '0;
    owner_d   = gnt[1] ? OWN_IF : (gnt[0] && !d_we) ? OWN_D : OWN_NONE;
    if_rvalid = owner_q == OWN_IF;
    d_rvalid  = owner_q == OWN_D;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid ? mem_rdata : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) owner_q <= OWN_NONE;
    else        owner_q <= owner_d;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random stimulus checked against a transaction-level arbiter model.
module tb_mem_arbiter;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic        clk = 0, reset = 0;
  logic        if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic [3:0]  d_be = 0;
  logic        if_ready, if_rvalid, d_ready, d_rvalid, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  int checks = 0, errors = 0;
  int pend = 0;
  bit fav_d = 1;
  bit acc_i, acc_d;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs();
    chk("rst_if_ready", if_ready, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);
  endtask

  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                      input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dwd);
    bit wi, wd;
    @(negedge clk);
    if_req = ir; if_addr = ia; d_req = dr; d_we = dwe; d_be = dbe; d_addr = da; d_wdata = dwd;
    mem_rdata = $urandom;
    #1;
    wi = 0; wd = 0;
    if (dr && ir) begin
      if (RR && !fav_d) wi = 1;
      else wd = 1;
    end else if (dr) wd = 1;
    else if (ir) wi = 1;
    chk("if_ready", if_ready, wi);
    chk("d_ready", d_ready, wd);
    chk("mem_en", mem_en, wi | wd);
    chk("mem_we", mem_we, wd & dwe);
    chk("mem_be", mem_be, (wd && dwe) ? dbe : 4'h0);
    chk("mem_addr", mem_addr, wd ? da : wi ? ia : 32'h0);
    chk("mem_wdata", mem_wdata, wd ? dwd : 32'h0);
    chk("if_rvalid", if_rvalid, pend == 1);
    chk("d_rvalid", d_rvalid, pend == 2);
    chk("if_rdata", if_rdata, pend == 1 ? mem_rdata : 32'h0);
    chk("d_rdata", d_rdata, pend == 2 ? mem_rdata : 32'h0);
    @(posedge clk);
    pend = wi ? 1 : (wd && !dwe) ? 2 : 0;
    if (RR && dr && ir) fav_d = wi;
    acc_i = wi; acc_d = wd;
  endtask

  initial begin
    logic        ir, dr, dwe;
    logic [31:0] ia, da, dwd;
    logic [3:0]  dbe;
    if_req = 1; d_req = 1; d_we = 1; d_be = 4'hf;
    #1;
    chk_idle_outputs();
    @(negedge clk);
    reset = 1;
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 32'(4 * i), 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h40, 1, 0, 4'h0, 32'h100, 0);
    step(1, 32'h40, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 4'b0011, 32'h20, 32'hDEADBEEF);
    step(0, 0, 1, 1, 4'b0000, 32'h24, 32'h12345678);
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 32'h200, 1, 0, 0, 32'h300, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // reset lands after a fetch is accepted but before it is registered
    step(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    if_req = 1; if_addr = 32'h80; d_req = 0;
    #1;
    chk("mid_if_ready", if_ready, 1);
    #2 reset = 0;
    #1;
    chk_idle_outputs();
    @(posedge clk);
    #1;
    chk_idle_outputs();
    @(negedge clk);
    if_req = 0;
    reset = 1;
    pend = 0; fav_d = 1;
    step(1, 32'h84, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    ir = 0; dr = 0; ia = 0; da = 0; dwe = 0; dbe = 0; dwd = 0;
    acc_i = 0; acc_d = 0;
    for (int i = 0; i < 600; i++) begin
      if (ir && !acc_i) ir = ($urandom_range(0, 9) != 0);
      else begin ir = $urandom_range(0, 1); ia = $urandom & 32'hffff_fffc; end
      if (dr && !acc_d) dr = ($urandom_range(0, 9) != 0);
      else begin
        dr = $urandom_range(0, 1); dwe = $urandom_range(0, 1);
        dbe = 4'($urandom); da = $urandom; dwd = $urandom;
      end
      step(ir, ia, dr, dwe, dbe, da, dwd);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port-to-one-port memory arbiter that shares the single-port synchronous program/data memory between the CPU instruction-fetch stage and the load/store unit. Sits between the CPU core and the memory macro. Accepts at most one access per cycle, tracks the owner of the outstanding read, and steers the one-cycle-latency read data back to the right requester. Write accesses complete on acceptance.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enables are DATA_W/8 bits wide
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; addr held stable until accepted
- if_addr  in  ADDR_W  fetch byte address
- if_ready  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DATA_W  fetch data
- d_req  in  1  data request; all d_* held stable until accepted
- d_we  in  1  1 = write, 0 = read
- d_be  in  DATA_W/8  write byte enables
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  write data
- d_ready  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid (never for writes)
- d_rdata  out  DATA_W  load data
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_be  out  DATA_W/8  memory byte enables
- mem_addr  out  ADDR_W  memory byte address (memory ignores addr[1:0])
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en with mem_we=0

## Operation
- Acceptance: request accepted in a cycle where req && ready. Exactly one of if_ready/d_ready high per cycle, only when the matching req is high.
- Grant (default): d_req wins over if_req when both high.
- Granted requester's fields drive mem_* combinationally; mem_en=1. Fetch: mem_we=0, mem_be=0. Data: mem_we=d_we, mem_be = d_we ? d_be : 0.
- No grant: mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- Owner register (OWN_NONE / OWN_IF / OWN_D): set on accepted read to its requester, set to OWN_NONE on accepted write or no acceptance.
- Response: cycle after a read acceptance, rvalid of owner =1 and its rdata = mem_rdata; other rdata = 0, other rvalid = 0.
- Full pipelining: new request acceptable in the same cycle a response returns; throughput one access per cycle.
- Write with d_be=0: accepted, mem_en=1, mem_we=1, mem_be=0 (no memory change).

## Timing
- ready and mem_* combinational from req (same cycle); rvalid/rdata exactly 1 cycle after acceptance.
- Reset (reset=0): owner=OWN_NONE, priority bit = data; all outputs 0 while reset low, including ready.
- Reset mid-operation: outstanding read dropped, its rvalid never asserted.
- Requester deasserting req before acceptance: legal, request withdrawn, no side effect.
- Back-to-back reads from same requester: one rvalid per accepted read, in order.

## Configuration
- MEM_ARB_RR_EN defined: on contention (both req high), winner alternates; priority bit flips to the loser after every contended grant; uncontended grants leave it unchanged; reset value favours data.
- Undefined: fixed priority, data always wins; fetch can starve under continuous d_req. Priority bit not implemented.

## Structure
- Shared package mem_arb_pkg: owner enum (OWN_NONE, OWN_IF, OWN_D), default ADDR_W/DATA_W constants.
- One sub-module: mem_arb_pick (combinational two-way picker with priority input, returns grant one-hot); top holds owner and priority registers and muxes.

## Test plan
- Fetch only: if_req=1, if_addr=0x0,0x4,0x8 consecutive -> if_ready=1 each cycle, if_rvalid=1 one cycle later each with mem_rdata data, d_rvalid=0.
- Contention fixed priority: if_req=d_req=1 (d load 0x100) -> d_ready=1, if_ready=0, mem_addr=0x100; next cycle d_rvalid=1, fetch granted.
- Data write: d_we=1, d_be=4'b0011, d_addr=0x20, d_wdata=0xDEADBEEF -> mem_en=1, mem_we=1, mem_be=4'b0011; no d_rvalid following.
- MEM_ARB_RR_EN: both req held high 4 cycles -> grants D, IF, D, IF; rvalids follow each by one cycle.
- Reset mid-read: accept fetch, drop reset low before next edge -> if_rvalid stays 0, all outputs 0; after release first request behaves normally.
